countdown_60: RTL and testbench

- Loadable two-digit decimal down-counter, 59..00. Units digit is modulo 10, tens digit is modulo 6.
- Emits a registered borrow-out pulse when the count is consumed at 00.
- It is the decrementing counterpart of the mod-6 up-counter with carry-out, and feeds countdown timers and cascaded down-count chains.

---
 rtl/countdown_60_pkg.sv | 14 +
 rtl/countdown_60_digit_down_cnt.sv | 29 ++
 rtl/countdown_60.sv | 136 +++++++++++++
 tb/tb_countdown_60.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/countdown_60_pkg.sv
// Shared types and defaults for the countdown_60 two-digit decimal down-counter.
package countdown_60_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DW_DEF        = 4;
  localparam int UNITS_MOD_DEF = 10;
  localparam int TENS_MOD_DEF  = 6;

endpackage

// File: rtl/countdown_60_digit_down_cnt.sv
// One modulo-MOD down-counting digit with synchronous load and combinational borrow.
module digit_down_cnt #(
  parameter int MOD = 10,
  parameter int DW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          ld,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          bout
);

  localparam logic [DW-1:0] MAX_Q = DW'(MOD - 1);

  assign bout = dec && (q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (dec) begin
      q <= (q == '0) ? MAX_Q : q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_60.sv
// Loadable 59..00 decimal down-counter with registered borrow-out.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: terminal event reloads the last loaded value and stays in RUN.
module countdown_60
  import countdown_60_pkg::*;
#(
  parameter int UNITS_MOD = UNITS_MOD_DEF,
  parameter int TENS_MOD  = TENS_MOD_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] load_units,
  input  logic [DW-1:0] load_tens,
  output logic [DW-1:0] units,
  output logic [DW-1:0] tens,
  output logic          bo,
  output logic          zero,
  output logic [1:0]    state
);

  localparam logic [DW-1:0] MAX_UNITS = DW'(UNITS_MOD - 1);
  localparam logic [DW-1:0] MAX_TENS  = DW'(TENS_MOD - 1);

  state_t        cur_state;
  state_t        nxt_state;
  logic          dec_units;
  logic          terminal;
  logic          ld_digits;
  logic [DW-1:0] units_c;
  logic [DW-1:0] tens_c;
  logic [DW-1:0] d_units;
  logic [DW-1:0] d_tens;
  logic          units_bout;
  logic          tens_bout_unused;

  assign units_c = (load_units > MAX_UNITS) ? MAX_UNITS : load_units;
  assign tens_c  = (load_tens  > MAX_TENS)  ? MAX_TENS  : load_tens;
  assign zero    = (units == '0) && (tens == '0);
  assign state   = cur_state;

  // Strobes, no handshake: load is taken on any edge it is high; en qualifies
  // one decrement per edge only in RUN and only when load is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    if (load) begin
      nxt_state = ST_RUN;
    end else begin
      case (cur_state)
        ST_IDLE: nxt_state = ST_IDLE;
        ST_RUN: begin
          if (en && zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            nxt_state = ST_RUN;
`else
            nxt_state = ST_DONE;
`endif
          end
        end
        ST_DONE: nxt_state = ST_DONE;
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_units = 1'b0;
    terminal  = 1'b0;
    if (!load && (cur_state == ST_RUN) && en) begin
      if (zero) terminal  = 1'b1;
      else      dec_units = 1'b1;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [DW-1:0] rel_units;
  logic [DW-1:0] rel_tens;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_units <= '0;
      rel_tens  <= '0;
    end else if (load) begin
      rel_units <= units_c;
      rel_tens  <= tens_c;
    end
  end

  assign ld_digits = load || terminal;
  assign d_units   = load ? units_c : rel_units;
  assign d_tens    = load ? tens_c  : rel_tens;
`else
  assign ld_digits = load;
  assign d_units   = units_c;
  assign d_tens    = tens_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bo <= 1'b0;
    end else begin
      bo <= terminal;
    end
  end

  digit_down_cnt #(.MOD(UNITS_MOD), .DW(DW)) u_units (
    .clk  (clk),
    .rst  (rst),
    .dec  (dec_units),
    .ld   (ld_digits),
    .d    (d_units),
    .q    (units),
    .bout (units_bout)
  );

  // Tens only moves when units borrows past zero.
  digit_down_cnt #(.MOD(TENS_MOD), .DW(DW)) u_tens (
    .clk  (clk),
    .rst  (rst),
    .dec  (units_bout),
    .ld   (ld_digits),
    .d    (d_tens),
    .q    (tens),
    .bout (tens_bout_unused)
  );

endmodule

// File: tb/tb_countdown_60.sv
// Scoreboard bench for countdown_60: count modelled as an integer 0..59.
module tb_countdown_60;

  localparam int W = 12;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_units;
  logic [3:0] load_tens;
  logic [3:0] units;
  logic [3:0] tens;
  logic       bo;
  logic       zero;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  int m_cnt;
  int m_rel;
  int m_st;
  bit m_bo;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  countdown_60 dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_units (load_units),
    .load_tens  (load_tens),
    .units      (units),
    .tens       (tens),
    .bo         (bo),
    .zero       (zero),
    .state      (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_pack();
    logic [1:0] s;
    logic [3:0] t;
    logic [3:0] u;
    s = 2'(m_st);
    t = 4'(m_cnt / 10);
    u = 4'(m_cnt % 10);
    return {s, m_bo, (m_cnt == 0), t, u};
  endfunction

  function automatic logic [W-1:0] dut_pack();
    return {state, bo, zero, tens, units};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_rel = 0;
    m_st  = M_IDLE;
    m_bo  = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit l, input int lu, input int lt);
    if (l) begin
      m_cnt = ((lt > 5) ? 5 : lt) * 10 + ((lu > 9) ? 9 : lu);
      m_rel = m_cnt;
      m_st  = M_RUN;
      m_bo  = 1'b0;
    end else if (m_st == M_RUN && e) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        m_bo  = 1'b0;
      end else begin
        m_bo = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_cnt = m_rel;
`else
        m_st = M_DONE;
`endif
      end
    end else begin
      m_bo = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%b bo=%b z=%b %0d%0d, want st=%b bo=%b z=%b %0d%0d",
               name, act[11:10], act[9], act[8], act[7:4], act[3:0],
               exp[11:10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  // Driver: apply inputs, advance model on the edge, push expected result.
  task automatic step(input bit e, input bit l, input int lu, input int lt);
    en         = e;
    load       = l;
    load_units = 4'(lu);
    load_tens  = 4'(lt);
    @(posedge clk);
    model_step(e, l, lu, lt);
    exp_q.push_back(model_pack());
    #1;
  endtask

  // Monitor: each cycle's outputs are compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("cycle", dut_pack(), e);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b0;
    en = 1'b0;
    load = 1'b0;
    load_units = '0;
    load_tens = '0;

    #50;
    check("reset_state", dut_pack(), model_pack());
    #50;
    rst = 1'b1;

    // 1: en without load stays idle
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

    // 2: load 25, count through the units wrap
    step(0, 1, 5, 2);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // 3: load 59, alternating en, then load beats en
    step(0, 1, 9, 5);
    for (int i = 0; i < 8; i++) step((i % 2) == 0, 0, 0, 0);
    step(1, 1, 9, 5);

    // 4: load 02 and run through the terminal event
    step(0, 1, 2, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0);

    // 5: clamping, then load 00 followed by en
    step(0, 1, 12, 7);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Randomised phase, biased toward small loads so terminal events are common
    for (int i = 0; i < 400; i++) begin
      bit e;
      bit l;
      int lu;
      int lt;
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 11) == 0);
      lu = $urandom_range(0, 15);
      lt = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
      step(e, l, lu, lt);
    end

    // 6: asynchronous reset mid-count
    step(0, 1, 7, 3);
    en = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_pack(), model_pack());
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    @(negedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
